// File: rtl/alu_sequencer.sv
// Instruction sequencer that drives an external ALU over a bgn/rdy handshake.
// Reads operands from an 8x16 register file and writes results, HI and flags back.
module alu_sequencer #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned NREGS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        alu_bgn,
    output logic [5:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_acc1,
    input  logic [15:0] alu_acc2,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_rdy,
    output logic [3:0]  flags,
    output logic [15:0] hi,
    output logic        done,
    output logic        err,
    output logic        halted,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 5;
    localparam int unsigned RAW = 3;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    localparam logic [OPW-1:0] OP_HLT = 5'b00000;
    localparam logic [OPW-1:0] OP_MUL = 5'b00111;
    localparam logic [OPW-1:0] OP_DIV = 5'b01000;
    localparam logic [OPW-1:0] OP_MOD = 5'b01001;
    localparam logic [OPW-1:0] OP_CMP = 5'b01110;
    localparam logic [OPW-1:0] OP_TST = 5'b01111;
    localparam logic [OPW-1:0] OP_DEC = 5'b10001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_HALT
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_regs [NREGS];
    logic [OPW-1:0]  r_op;
    logic [RAW-1:0]  r_rd;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_acc1;
    logic [DW-1:0]   r_acc2;
    logic [3:0]      r_cap_flags;
    logic            r_instr_ready;
    logic            r_alu_bgn;
    logic [5:0]      r_alu_opcode;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [3:0]      r_flags;
    logic [DW-1:0]   r_hi;
    logic            r_done;
    logic            r_err;
    logic            r_halted;

    logic [OPW-1:0]  w_in_op;
    logic            w_unused_bits;

    // Opcodes outside HLT..DEC (other than HLT itself) are NOPs.
    function automatic logic f_is_alu(input logic [OPW-1:0] op);
        return (op != OP_HLT) && (op <= OP_DEC);
    endfunction

    assign w_in_op       = instr[15:11];
    assign w_unused_bits = ^instr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_regs        <= '{default: '0};
            r_op          <= '0;
            r_rd          <= '0;
            r_cnt         <= '0;
            r_acc1        <= '0;
            r_acc2        <= '0;
            r_cap_flags   <= '0;
            r_instr_ready <= 1'b1;
            r_alu_bgn     <= 1'b0;
            r_alu_opcode  <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_flags       <= '0;
            r_hi          <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op          <= w_in_op;
                        r_rd          <= instr[10:8];
                        r_instr_ready <= 1'b0;
                        if (w_in_op == OP_HLT) begin
                            r_state  <= S_HALT;
                            r_done   <= 1'b1;
                            r_halted <= 1'b1;
                        end else if (f_is_alu(w_in_op)) begin
                            // Operands are sampled here so a pending rd==rs write cannot leak in.
                            r_state      <= S_ISSUE;
                            r_alu_bgn    <= 1'b1;
                            r_alu_a      <= r_regs[instr[7:5]];
                            r_alu_b      <= r_regs[instr[4:2]];
                            r_alu_opcode <= {1'b0, w_in_op};
                        end else begin
                            r_state <= S_WB;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_alu_bgn <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // rdy on the first WAIT cycle may still belong to the previous op.
                    if (alu_rdy && (r_cnt != '0)) begin
                        r_acc1      <= alu_acc1;
                        r_acc2      <= alu_acc2;
                        r_cap_flags <= {alu_zero, alu_negative, alu_carry, alu_overflow};
                        r_state     <= S_WB;
                        r_done      <= 1'b1;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err         <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= S_IDLE;
                        r_instr_ready <= 1'b1;
                    end
                end
                S_WB: begin
                    if (f_is_alu(r_op)) begin
                        if ((r_op != OP_CMP) && (r_op != OP_TST)) begin
                            r_regs[r_rd] <= r_acc1;
                        end
                        if ((r_op == OP_MUL) || (r_op == OP_DIV) || (r_op == OP_MOD)) begin
                            r_hi <= r_acc2;
                        end
                        r_flags <= r_cap_flags;
                    end
                    r_state       <= S_IDLE;
                    r_instr_ready <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign alu_bgn     = r_alu_bgn;
    assign alu_opcode  = r_alu_opcode;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign flags       = r_flags;
    assign hi          = r_hi;
    assign done        = r_done;
    assign err         = r_err;
    assign halted      = r_halted;
    assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a stub ALU returns chosen results and a
// register-file model predicts writeback, HI, flags, err, halt and done latency.
module tb_alu_sequencer;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned HALF    = 10;

    localparam int M_NORMAL = 0;
    localparam int M_STALE  = 1;
    localparam int M_NEVER  = 2;

    localparam logic [4:0] OP_HLT = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_XOR = 5'd12;
    localparam logic [4:0] OP_CMP = 5'd14;
    localparam logic [4:0] OP_NOP = 5'd31;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        alu_bgn;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_acc1;
    logic [15:0] alu_acc2;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_rdy;
    logic [3:0]  flags;
    logic [15:0] hi;
    logic        done;
    logic        err;
    logic        halted;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_sequencer #(.TIMEOUT(TIMEOUT), .NREGS(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_acc1(alu_acc1), .alu_acc2(alu_acc2),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_rdy(alu_rdy),
        .flags(flags), .hi(hi), .done(done), .err(err), .halted(halted),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  opc;
        int          mode;
        int          d;
        logic [15:0] acc1;
        logic [15:0] acc2;
        logic [3:0]  fl;
    } resp_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] rdval;
        logic [15:0] hi;
        logic [3:0]  fl;
        logic        err;
        logic        halted;
        longint      t_acc;
        int          k;
    } exp_t;

    resp_t       resp_q[$];
    exp_t        exp_q[$];
    logic [15:0] m_regs [8];
    logic [15:0] m_hi;
    logic [3:0]  m_flags;
    logic        m_err;
    logic        m_halted;
    int          n_checks;
    int          n_fail;

    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_hi     = '0;
        m_flags  = '0;
        m_err    = 1'b0;
        m_halted = 1'b0;
    endtask

    // Issue one instruction at a negedge; updates the model at the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input int mode, input int d,
                         input logic [15:0] acc1, input logic [15:0] acc2, input logic [3:0] fl);
        int    w;
        resp_t r;
        exp_t  e;
        logic  is_alu;
        instr       = {op, rd, rs1, rs2, 2'b00};
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.t_acc = $time;
            e.rd    = rd;
            e.k     = 0;
            is_alu  = (op >= 5'd1) && (op <= 5'd17);
            if (op == OP_HLT) begin
                m_halted = 1'b1;
            end else if (is_alu) begin
                r.a = m_regs[rs1]; r.b = m_regs[rs2]; r.opc = {1'b0, op};
                r.mode = mode; r.d = d; r.acc1 = acc1; r.acc2 = acc2; r.fl = fl;
                resp_q.push_back(r);
                if (mode == M_NEVER) begin
                    m_err = 1'b1;
                    e.k   = TIMEOUT + 1;
                end else begin
                    if (op != 5'd14 && op != 5'd15) m_regs[rd] = acc1;
                    if (op == 5'd7 || op == 5'd8 || op == 5'd9) m_hi = acc2;
                    m_flags = fl;
                    e.k = (mode == M_STALE) ? 3 : d + 1;
                end
            end
            e.rdval = m_regs[rd]; e.hi = m_hi; e.fl = m_flags;
            e.err = m_err; e.halted = m_halted;
            exp_q.push_back(e);
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_bgn", 32'(alu_bgn), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_ready_now", 32'(instr_ready), 32'd1);
        exp_q.delete();
        resp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Stub ALU: pops the response chosen at issue and returns it on the planned WAIT cycle.
    initial begin
        resp_t cur;
        int    n;
        bit    active;
        active = 1'b0; n = 0;
        alu_rdy = 1'b0; alu_acc1 = '0; alu_acc2 = '0;
        {alu_zero, alu_negative, alu_carry, alu_overflow} = 4'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                active  = 1'b0;
                alu_rdy = 1'b0;
            end else if (active) begin
                n++;
                if (n == 1) chk("bgn_width", 32'(alu_bgn), 32'd0);
                if (cur.mode == M_NORMAL) begin
                    if (n == cur.d) begin
                        chk("a_stable", 32'(alu_a), 32'(cur.a));
                        chk("b_stable", 32'(alu_b), 32'(cur.b));
                        alu_acc1 = cur.acc1; alu_acc2 = cur.acc2;
                        {alu_zero, alu_negative, alu_carry, alu_overflow} = cur.fl;
                        alu_rdy = 1'b1;
                    end else if (n == cur.d + 1) begin
                        alu_rdy = 1'b0;
                        active  = 1'b0;
                    end
                end else if (cur.mode == M_STALE) begin
                    if (n == 2) begin
                        chk("opc_stable", 32'(alu_opcode), 32'(cur.opc));
                        alu_acc1 = cur.acc1; alu_acc2 = cur.acc2;
                        {alu_zero, alu_negative, alu_carry, alu_overflow} = cur.fl;
                    end else if (n == 3) begin
                        active = 1'b0;
                    end
                end else if (n == TIMEOUT + 1) begin
                    active = 1'b0;
                end
            end else if (alu_bgn) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_bgn", 32'(alu_bgn), 32'd0);
                end else begin
                    cur = resp_q.pop_front();
                    chk("alu_a", 32'(alu_a), 32'(cur.a));
                    chk("alu_b", 32'(alu_b), 32'(cur.b));
                    chk("alu_opcode", 32'(alu_opcode), 32'(cur.opc));
                    n = 0;
                    active = 1'b1;
                    if (cur.mode == M_STALE) begin
                        alu_rdy  = 1'b1;
                        alu_acc1 = ~cur.acc1; alu_acc2 = ~cur.acc2;
                        {alu_zero, alu_negative, alu_carry, alu_overflow} = ~cur.fl;
                    end else begin
                        alu_rdy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: checks done latency, then architectural state the cycle after.
    initial begin
        exp_t pend;
        exp_t e;
        bit   have_pend;
        bit   need_sweep;
        have_pend = 1'b0; need_sweep = 1'b0;
        pend = '{default: '0};
        dbg_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_pend  = 1'b0;
                need_sweep = 1'b1;
            end else begin
                if (need_sweep) begin
                    need_sweep = 1'b0;
                    chk("rst_ready", 32'(instr_ready), 32'd1);
                    chk("rst_halted", 32'(halted), 32'd0);
                    chk("rst_err", 32'(err), 32'd0);
                    chk("rst_hi", 32'(hi), 32'd0);
                    chk("rst_flags", 32'(flags), 32'd0);
                    for (int i = 0; i < 8; i++) begin
                        dbg_addr = 3'(i);
                        #1;
                        chk("rst_reg", 32'(dbg_data), 32'd0);
                    end
                end
                if (have_pend) begin
                    have_pend = 1'b0;
                    dbg_addr  = pend.rd;
                    #1;
                    chk("reg_rd", 32'(dbg_data), 32'(pend.rdval));
                    chk("hi", 32'(hi), 32'(pend.hi));
                    chk("flags", 32'(flags), 32'(pend.fl));
                    chk("err", 32'(err), 32'(pend.err));
                    chk("halted", 32'(halted), 32'(pend.halted));
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_latency", 32'($time - HALF - e.t_acc), 32'(e.k * 2 * HALF));
                        pend      = e;
                        have_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        int         v;
        int         md;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        issue(OP_ADD, 3'd1, 3'd0, 3'd0, M_NORMAL, 2, 16'h0005, 16'h0000, 4'b0000);
        issue(OP_ADD, 3'd2, 3'd0, 3'd0, M_NORMAL, 2, 16'h0003, 16'h0000, 4'b0000);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, M_NORMAL, 2, 16'h0008, 16'h0000, 4'b0000);
        issue(OP_MUL, 3'd4, 3'd1, 3'd2, M_NORMAL, 3, 16'h000F, 16'h0001, 4'b0010);
        issue(OP_CMP, 3'd5, 3'd1, 3'd2, M_NORMAL, 2, 16'hBEEF, 16'h1234, 4'b1000);
        issue(OP_ADD, 3'd6, 3'd4, 3'd3, M_NEVER, 0, 16'h7777, 16'h0000, 4'b0101);
        issue(OP_SUB, 3'd6, 3'd6, 3'd6, M_NORMAL, 4, 16'h0000, 16'h0000, 4'b1000);
        issue(OP_XOR, 3'd7, 3'd4, 3'd1, M_STALE, 0, 16'h000A, 16'h0000, 4'b0100);
        drain();

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 19));
            if (v < 17)       op = 5'(v + 1);
            else if (v == 17) op = OP_NOP;
            else if (v == 18) op = 5'(18 + $urandom_range(0, 12));
            else              op = OP_ADD;
            v  = int'($urandom_range(0, 15));
            md = (v == 0) ? M_NEVER : ((v < 3) ? M_STALE : M_NORMAL);
            issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  md, int'($urandom_range(2, 5)), 16'($urandom), 16'($urandom), 4'($urandom));
        end
        drain();

        issue(OP_ADD, 3'd2, 3'd1, 3'd1, M_NEVER, 0, 16'h1111, 16'h0000, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        do_reset();

        issue(OP_ADD, 3'd1, 3'd0, 3'd0, M_NORMAL, 2, 16'h0005, 16'h0000, 4'b0001);
        issue(OP_NOP, 3'd1, 3'd0, 3'd0, M_NORMAL, 2, 16'hFFFF, 16'h0000, 4'b1111);
        issue(OP_HLT, 3'd1, 3'd0, 3'd0, M_NORMAL, 2, 16'h0000, 16'h0000, 4'b0000);
        drain();
        instr       = {OP_ADD, 3'd2, 3'd1, 3'd1, 2'b00};
        instr_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("halt_ready", 32'(instr_ready), 32'd0);
        end
        chk("halt_flag", 32'(halted), 32'd1);
        instr_valid = 1'b0;
        do_reset();
        issue(OP_ADD, 3'd5, 3'd0, 3'd0, M_NORMAL, 3, 16'hA5A5, 16'h0000, 4'b0010);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the ALU bgn/rdy handshake.
- Accepts 16-bit instruction words over a valid/ready interface and reads two operands from an internal 8x16 register file.
- Drives the ALU's opcode, A, B and bgn lines, waits for the ALU's rdy, then writes acc1 back to the destination register and acc2 to a HI register.
- Latches the ALU flags and sits between instruction fetch and the ALU.

Parameters:
TIMEOUT, 64, maximum cycles to wait for alu_rdy before aborting the op
NREGS, 8, register file depth (fixed at 8; 3-bit register fields)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction word present
instr_ready  out  1  sequencer can accept an instruction (high only in IDLE)
instr  in  16  [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] ignored
alu_bgn  out  1  start pulse to ALU
alu_opcode  out  6  {1'b0, opcode[4:0]}
alu_a  out  16  operand A = R[rs1]
alu_b  out  16  operand B = R[rs2]
alu_acc1  in  16  ALU low result
alu_acc2  in  16  ALU high result / remainder
alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  ALU flags
alu_rdy  in  1  ALU result valid
flags  out  4  latched {zero, negative, carry, overflow}
hi  out  16  latched acc2 of last MUL/DIV/MOD
done  out  1  one-cycle pulse when an instruction retires
err  out  1  sticky; set on ALU timeout
halted  out  1  high once HLT has retired
dbg_addr  in  3  register file debug read address
dbg_data  out  16  R[dbg_addr], combinational

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; R0..R7=0; hi=0; flags=0; alu_bgn=0; alu_opcode/alu_a/alu_b=0; done=0; err=0; halted=0; timeout counter=0.
- Reset overrides everything, including mid-operation: any in-flight ALU op is abandoned and its result is never written back.
- Opcode encoding: HLT=00000, ADD=00001, SUB=00010, LSR=00011, LSL=00100, RSR=00101, RSL=00110, MUL=00111, DIV=01000, MOD=01001, AND=01010, OR=01011, XOR=01100, NOT=01101, CMP=01110, TST=01111, INC=10000, DEC=10001, NOP=11111.
- Any other opcode is treated as NOP.
- States:
  - IDLE: instr_ready=1. On instr_valid, latch instr. If the opcode is NOP, go to WB with no ALU access. If HLT, go to HALT. Otherwise go to ISSUE.
  - ISSUE (1 cycle): drive alu_a=R[rs1], alu_b=R[rs2] and alu_opcode; alu_bgn=1 for exactly this cycle; clear the counter; go to WAIT.
    - alu_a, alu_b and alu_opcode stay stable from ISSUE until WB is entered.
  - WAIT: alu_bgn=0 and the counter increments every cycle.
    - alu_rdy is ignored on the first WAIT cycle (it may hold a stale value from the previous op).
    - From the second WAIT cycle on, alu_rdy=1 captures acc1, acc2 and the flags, then goes to WB.
    - If the counter reaches TIMEOUT, set err, skip writeback, pulse done and go to IDLE.
  - WB (1 cycle), writeback per opcode:
    - R[rd]<=acc1 for every ALU op except CMP and TST.
    - hi<=acc2 for MUL, DIV and MOD.
    - flags updated for every ALU op; NOP leaves flags unchanged.
    - done=1; go to IDLE.
  - HALT: done pulses on entry, halted=1, instr_ready=0. Stays here until rst.
- Minimum latency: instr accepted at edge N, done high in cycle N+4 with rdy seen on the second WAIT cycle. NOP gives done at N+1.
- Back-to-back: a new instruction may be accepted in the cycle after WB.
- rd equal to rs1 or rs2 is legal. Operands are read in ISSUE, before writeback.
- Writes to R[rd] are visible on dbg_data in the cycle after WB.
- alu_opcode[5] is always 0.
- err clears only on rst.

Test Plan:
- Reset, then dbg_addr sweep 0..7 -> dbg_data=0 for all; instr_ready=1; halted=0; err=0.
- Preload R1=0x0005 and R2=0x0003 via ADD instructions, with the bench ALU model returning rdy on the 2nd WAIT cycle. Issue ADD rd=3,rs1=1,rs2=2 -> alu_bgn high for exactly 1 cycle with alu_a=5, alu_b=3, alu_opcode=6'b000001; done 4 cycles after acceptance; R3=0x0008.
- MUL rd=4,rs1=1,rs2=2 with the model returning acc1=0x000F, acc2=0x0001 -> R4=0x000F, hi=0x0001. Then CMP rd=5 returning acc1=0xBEEF -> R5 unchanged, flags updated.
- Bench ALU never asserts rdy, TIMEOUT=64 -> done and err set 64 WAIT cycles after bgn; rd unchanged; next instruction still accepted.
- Stale-rdy case: hold alu_rdy=1 continuously -> result captured no earlier than the 2nd WAIT cycle. Separately, assert rst during WAIT -> state IDLE, alu_bgn=0, rd unchanged.
- NOP, then HLT, then an ADD presented with instr_valid held -> NOP gives done at +1 cycle with no bgn; HLT sets halted=1; instr_ready stays 0 and the ADD is never accepted until rst.
